ccx_ic_arbiter_n: RTL and testbench



---
 rtl/ccx_ic_arbiter_n_if.sv | 45 ++++
 rtl/ccx_ic_arbiter_n.sv | 153 +++++++++++++++
 tb/tb_ccx_ic_arbiter_n.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccx_ic_arbiter_n_if.sv
// Bus bundle between N requestor channels and the single memory target port.
// The master modport is the arbiter's view; slave is the requestors/target side.
interface ccx_ic_arbiter_n_if #(
    parameter int N  = 4,
    parameter int AW = 39,
    parameter int DW = 64
);
    localparam int SW = DW / 8;

    logic [N-1:0]    req_req;
    logic [N-1:0]    req_gnt;
    logic [N-1:0]    req_wen;
    logic [N*SW-1:0] req_strb;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_recv;
    logic [N-1:0]    req_ack;
    logic            req_error;
    logic [DW-1:0]   req_rdata;

    logic            tgt_req;
    logic            tgt_gnt;
    logic            tgt_wen;
    logic [SW-1:0]   tgt_strb;
    logic [AW-1:0]   tgt_addr;
    logic [DW-1:0]   tgt_wdata;
    logic            tgt_recv;
    logic            tgt_ack;
    logic            tgt_error;
    logic [DW-1:0]   tgt_rdata;

    modport master (
        input  req_req, req_wen, req_strb, req_addr, req_wdata, req_ack,
        input  tgt_gnt, tgt_recv, tgt_error, tgt_rdata,
        output req_gnt, req_recv, req_error, req_rdata,
        output tgt_req, tgt_wen, tgt_strb, tgt_addr, tgt_wdata, tgt_ack
    );

    modport slave (
        output req_req, req_wen, req_strb, req_addr, req_wdata, req_ack,
        output tgt_gnt, tgt_recv, tgt_error, tgt_rdata,
        input  req_gnt, req_recv, req_error, req_rdata,
        input  tgt_req, tgt_wen, tgt_strb, tgt_addr, tgt_wdata, tgt_ack
    );
endinterface

// File: rtl/ccx_ic_arbiter_n.sv
// N-to-1 core memory bus arbiter: fixed-priority or round-robin selection with
// a selection lock, zero-latency forwarding and in-order response routing via an ID FIFO.
module ccx_ic_arbiter_n #(
    parameter int N       = 4,
    parameter int AW      = 39,
    parameter int DW      = 64,
    parameter int MODE    = 1,
    parameter int MAX_OUT = 2,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(MAX_OUT + 1),
    localparam int PW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic                g_clk,
    input  logic                g_reset,
    ccx_ic_arbiter_n_if.master  bus,
    output logic [CW-1:0]       outstanding,
    output logic                stray_rsp
);
    localparam int SW = DW / 8;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] lock_id;
    logic           lock_vld;
    logic [IDW-1:0] arb_sel;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;

    logic [IDW-1:0] fifo_mem [MAX_OUT];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic any_req;
    logic fifo_full;
    logic fifo_empty;
    logic grant_ok;
    logic accept;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [IDW-1:0] id_inc(input logic [IDW-1:0] id);
        return (id == IDW'(N - 1)) ? '0 : id + IDW'(1);
    endfunction

    assign any_req    = |bus.req_req;
    assign fifo_full  = (count == CW'(MAX_OUT));
    assign fifo_empty = (count == '0);
    // Reset gating keeps every handshake output quiet while g_reset is high.
    assign grant_ok   = !g_reset && !fifo_full;
    assign head       = fifo_mem[rd_ptr];

    // Priority search: fixed order from 0, or rotating order starting at rr_ptr.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        arb_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 0) idx = k;
            else           idx = (int'(rr_ptr) + k) % N;
            if (!found && bus.req_req[idx]) begin
                found   = 1'b1;
                arb_sel = IDW'(idx);
            end
        end
    end

    // A stalled requestor keeps the port until accepted, so later arrivals cannot preempt it.
    assign sel = (lock_vld && bus.req_req[lock_id]) ? lock_id : arb_sel;

    assign bus.tgt_req = any_req && grant_ok;
    assign accept      = bus.tgt_req && bus.tgt_gnt;

    always_comb begin
        bus.req_gnt   = '0;
        bus.tgt_wen   = 1'b0;
        bus.tgt_strb  = '0;
        bus.tgt_addr  = '0;
        bus.tgt_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IDW'(i)) begin
                bus.req_gnt[i] = accept;
                bus.tgt_wen    = bus.req_wen[i];
                bus.tgt_strb   = bus.req_strb[i*SW +: SW];
                bus.tgt_addr   = bus.req_addr[i*AW +: AW];
                bus.tgt_wdata  = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    // Responses go to the FIFO head; with nothing outstanding they are drained as strays.
    always_comb begin
        bus.req_recv = '0;
        bus.tgt_ack  = 1'b0;
        if (!g_reset) begin
            if (fifo_empty) begin
                bus.tgt_ack = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (head == IDW'(i)) begin
                        bus.req_recv[i] = bus.tgt_recv;
                        bus.tgt_ack     = bus.req_ack[i];
                    end
                end
            end
        end
    end

    assign bus.req_rdata = bus.tgt_rdata;
    assign bus.req_error = bus.tgt_error;
    assign pop           = bus.tgt_recv && bus.tgt_ack && !fifo_empty;
    assign outstanding   = count;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rr_ptr    <= '0;
            lock_vld  <= 1'b0;
            lock_id   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stray_rsp <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) fifo_mem[i] <= '0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= sel;
                wr_ptr           <= ptr_inc(wr_ptr);
                lock_vld         <= 1'b0;
                if (MODE == 1) rr_ptr <= id_inc(sel);
            end else if (any_req) begin
                lock_vld <= 1'b1;
                lock_id  <= sel;
            end else begin
                lock_vld <= 1'b0;
            end

            if (pop) rd_ptr <= ptr_inc(rd_ptr);

            // Push is blocked when full, so count cannot pass MAX_OUT.
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (bus.tgt_recv && fifo_empty) stray_rsp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ccx_ic_arbiter_n.sv
// Bench for ccx_ic_arbiter_n: a fixed-priority and a round-robin instance, checked
// against grant/response expectations queued as stimulus is applied.
module tb_ccx_ic_arbiter_n;
    localparam int N  = 4;
    localparam int AW = 39;
    localparam int DW = 64;

    typedef struct {
        int          ch;
        logic [63:0] rd;
    } rsp_t;

    logic       g_clk;
    logic       g_reset;
    logic [1:0] out0, out1;
    logic       stray0, stray1;

    int   total = 0;
    int   bad   = 0;
    int   gnt_q[$];
    rsp_t rsp_q[$];
    logic [N-1:0] wen_pat = 4'b0101;

    ccx_ic_arbiter_n_if #(.N(N), .AW(AW), .DW(DW)) b0 ();
    ccx_ic_arbiter_n_if #(.N(N), .AW(AW), .DW(DW)) b1 ();

    ccx_ic_arbiter_n #(.N(N), .AW(AW), .DW(DW), .MODE(0), .MAX_OUT(2)) u_dut0 (
        .g_clk(g_clk), .g_reset(g_reset), .bus(b0), .outstanding(out0), .stray_rsp(stray0));
    ccx_ic_arbiter_n #(.N(N), .AW(AW), .DW(DW), .MODE(1), .MAX_OUT(2)) u_dut1 (
        .g_clk(g_clk), .g_reset(g_reset), .bus(b1), .outstanding(out1), .stray_rsp(stray1));

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] addr_of(input int ch);
        return 39'h40_0000_1000 + AW'(ch * 16);
    endfunction

    task automatic init_buses;
        for (int c = 0; c < N; c++) begin
            b0.req_addr[c*AW +: AW]   = addr_of(c);
            b1.req_addr[c*AW +: AW]   = addr_of(c);
            b0.req_wdata[c*DW +: DW]  = 64'hC0DE_0000_0000_0000 + 64'(c);
            b1.req_wdata[c*DW +: DW]  = 64'hC0DE_0000_0000_0000 + 64'(c);
        end
        b0.req_strb = '1;   b1.req_strb = '1;
        b0.req_wen  = wen_pat; b1.req_wen = wen_pat;
        b0.req_req  = '0;   b1.req_req  = '0;
        b0.req_ack  = '1;   b1.req_ack  = '1;
        b0.tgt_gnt  = 1'b0; b1.tgt_gnt  = 1'b0;
        b0.tgt_recv = 1'b0; b1.tgt_recv = 1'b0;
        b0.tgt_error = 1'b0; b1.tgt_error = 1'b0;
        b0.tgt_rdata = '0;  b1.tgt_rdata = '0;
    endtask

    task automatic test_reset;
        g_reset = 1'b1;
        b1.req_req = 4'b1111; b1.tgt_gnt = 1'b1; b1.tgt_recv = 1'b1;
        repeat (2) @(posedge g_clk);
        #5;
        total++; if (b1.tgt_req !== 1'b0) begin bad++; $display("FAIL rst_tgt_req got=%b want=0", b1.tgt_req); end
        total++; if (b1.req_gnt !== 4'b0) begin bad++; $display("FAIL rst_gnt got=%b want=0000", b1.req_gnt); end
        total++; if (b1.req_recv !== 4'b0) begin bad++; $display("FAIL rst_recv got=%b want=0000", b1.req_recv); end
        total++; if (b1.tgt_ack !== 1'b0) begin bad++; $display("FAIL rst_tgt_ack got=%b want=0", b1.tgt_ack); end
        total++; if (out1 !== 2'd0 || out0 !== 2'd0) begin bad++; $display("FAIL rst_outstanding got=%0d/%0d want=0", out0, out1); end
        total++; if (stray1 !== 1'b0 || stray0 !== 1'b0) begin bad++; $display("FAIL rst_stray got=%b/%b want=0", stray0, stray1); end
        b1.req_req = '0; b1.tgt_gnt = 1'b0; b1.tgt_recv = 1'b0;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        #4;
        total++; if (out1 !== 2'd0 || stray1 !== 1'b0) begin bad++; $display("FAIL rst_release got=%0d,%b want=0,0", out1, stray1); end
    endtask

    task automatic test_fixed_priority;
        rsp_t r;
        rsp_q.delete();
        for (int k = 0; k < 6; k++) begin
            @(posedge g_clk); #1;
            b0.req_req = 4'b1010; b0.tgt_gnt = 1'b1;
            b0.tgt_recv = (k > 0); b0.tgt_rdata = 64'hF000 + 64'(k);
            #4;
            total++; if (b0.req_gnt !== 4'b0010) begin bad++; $display("FAIL fp_gnt cyc%0d got=%b want=0010", k, b0.req_gnt); end
            total++; if (b0.tgt_addr !== addr_of(1)) begin bad++; $display("FAIL fp_addr cyc%0d got=%h want=%h", k, b0.tgt_addr, addr_of(1)); end
            if (k > 0) begin
                r = rsp_q.pop_front();
                total++; if (b0.req_recv !== 4'(1 << r.ch) || b0.req_rdata !== r.rd) begin
                    bad++; $display("FAIL fp_recv cyc%0d got=%b/%h want=%b/%h", k, b0.req_recv, b0.req_rdata, 4'(1 << r.ch), r.rd); end
            end
            rsp_q.push_back('{ch: 1, rd: 64'hF000 + 64'(k + 1)});
        end
        @(posedge g_clk); #1;
        b0.req_req = '0; b0.tgt_gnt = 1'b0; b0.tgt_recv = 1'b1; b0.tgt_rdata = 64'hF006;
        #4;
        r = rsp_q.pop_front();
        total++; if (b0.req_recv !== 4'(1 << r.ch) || b0.req_rdata !== r.rd) begin
            bad++; $display("FAIL fp_drain got=%b/%h want=%b/%h", b0.req_recv, b0.req_rdata, 4'(1 << r.ch), r.rd); end
        @(posedge g_clk); #1;
        b0.tgt_recv = 1'b0;
        #4;
        total++; if (out0 !== 2'd0) begin bad++; $display("FAIL fp_outstanding got=%0d want=0", out0); end
    endtask

    task automatic test_lock;
        rsp_t r;
        rsp_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(posedge g_clk); #1;
            b0.req_req = (k < 2) ? 4'b0100 : 4'b0101; b0.tgt_gnt = 1'b0;
            #4;
            total++; if (b0.tgt_addr !== addr_of(2) || b0.req_gnt !== 4'b0 || b0.tgt_req !== 1'b1) begin
                bad++; $display("FAIL lock_hold cyc%0d got=%h/%b/%b want=%h/0000/1", k, b0.tgt_addr, b0.req_gnt, b0.tgt_req, addr_of(2)); end
        end
        @(posedge g_clk); #1;
        b0.tgt_gnt = 1'b1;
        #4;
        total++; if (b0.req_gnt !== 4'b0100 || b0.tgt_addr !== addr_of(2)) begin
            bad++; $display("FAIL lock_first got=%b/%h want=0100/%h", b0.req_gnt, b0.tgt_addr, addr_of(2)); end
        rsp_q.push_back('{ch: 2, rd: 64'h1111});
        @(posedge g_clk); #1;
        b0.req_req = 4'b0001;
        #4;
        total++; if (b0.req_gnt !== 4'b0001 || b0.tgt_addr !== addr_of(0)) begin
            bad++; $display("FAIL lock_second got=%b/%h want=0001/%h", b0.req_gnt, b0.tgt_addr, addr_of(0)); end
        rsp_q.push_back('{ch: 0, rd: 64'h2222});
        @(posedge g_clk); #1;
        b0.req_req = '0; b0.tgt_gnt = 1'b0;
        #4;
        total++; if (out0 !== 2'd2) begin bad++; $display("FAIL lock_outstanding got=%0d want=2", out0); end
        for (int k = 0; k < 2; k++) begin
            r = rsp_q.pop_front();
            @(posedge g_clk); #1;
            b0.tgt_recv = 1'b1; b0.tgt_rdata = r.rd;
            #4;
            total++; if (b0.req_recv !== 4'(1 << r.ch) || b0.req_rdata !== r.rd) begin
                bad++; $display("FAIL lock_rsp%0d got=%b/%h want=%b/%h", k, b0.req_recv, b0.req_rdata, 4'(1 << r.ch), r.rd); end
        end
        @(posedge g_clk); #1;
        b0.tgt_recv = 1'b0;
        #4;
        total++; if (out0 !== 2'd0) begin bad++; $display("FAIL lock_drained got=%0d want=0", out0); end
    endtask

    task automatic test_round_robin;
        rsp_t r;
        int   e;
        gnt_q = '{0, 1, 2, 3, 0};
        rsp_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(posedge g_clk); #1;
            b1.req_req = 4'b1111; b1.tgt_gnt = 1'b1; b1.req_ack = '1;
            b1.tgt_recv = (k > 0); b1.tgt_rdata = 64'hD000 + 64'(k);
            #4;
            e = gnt_q.pop_front();
            total++; if (b1.req_gnt !== 4'(1 << e)) begin bad++; $display("FAIL rr_gnt cyc%0d got=%b want=%b", k, b1.req_gnt, 4'(1 << e)); end
            total++; if (b1.tgt_addr !== addr_of(e) || b1.tgt_wen !== wen_pat[e]) begin
                bad++; $display("FAIL rr_payload cyc%0d got=%h/%b want=%h/%b", k, b1.tgt_addr, b1.tgt_wen, addr_of(e), wen_pat[e]); end
            if (k > 0) begin
                r = rsp_q.pop_front();
                total++; if (b1.req_recv !== 4'(1 << r.ch) || b1.req_rdata !== r.rd) begin
                    bad++; $display("FAIL rr_recv cyc%0d got=%b/%h want=%b/%h", k, b1.req_recv, b1.req_rdata, 4'(1 << r.ch), r.rd); end
            end
            rsp_q.push_back('{ch: e, rd: 64'hD000 + 64'(k + 1)});
        end
        @(posedge g_clk); #1;
        b1.req_req = '0; b1.tgt_gnt = 1'b0; b1.tgt_recv = 1'b1; b1.tgt_rdata = 64'hD005;
        #4;
        r = rsp_q.pop_front();
        total++; if (b1.req_recv !== 4'(1 << r.ch) || b1.req_rdata !== r.rd) begin
            bad++; $display("FAIL rr_drain got=%b/%h want=%b/%h", b1.req_recv, b1.req_rdata, 4'(1 << r.ch), r.rd); end
        @(posedge g_clk); #1;
        b1.tgt_recv = 1'b0;
        #4;
        total++; if (out1 !== 2'd0) begin bad++; $display("FAIL rr_outstanding got=%0d want=0", out1); end
    endtask

    task automatic test_full_and_responses;
        rsp_t r;
        rsp_q.delete();
        @(posedge g_clk); #1;
        b1.req_req = 4'b1010; b1.tgt_gnt = 1'b1;
        #4;
        total++; if (b1.req_gnt !== 4'b0010) begin bad++; $display("FAIL full_gnt1 got=%b want=0010", b1.req_gnt); end
        rsp_q.push_back('{ch: 1, rd: 64'hA5});
        @(posedge g_clk); #1;
        b1.req_req = 4'b1000;
        #4;
        total++; if (b1.req_gnt !== 4'b1000 || out1 !== 2'd1) begin bad++; $display("FAIL full_gnt3 got=%b/%0d want=1000/1", b1.req_gnt, out1); end
        rsp_q.push_back('{ch: 3, rd: 64'h5A});
        @(posedge g_clk); #1;
        b1.req_req = 4'b0001;
        #4;
        total++; if (out1 !== 2'd2 || b1.tgt_req !== 1'b0 || b1.req_gnt !== 4'b0) begin
            bad++; $display("FAIL full_block got=%0d/%b/%b want=2/0/0000", out1, b1.tgt_req, b1.req_gnt); end
        r = rsp_q.pop_front();
        @(posedge g_clk); #1;
        b1.tgt_recv = 1'b1; b1.tgt_rdata = r.rd;
        #4;
        total++; if (b1.req_recv !== 4'(1 << r.ch) || b1.req_rdata !== r.rd || b1.tgt_ack !== 1'b1) begin
            bad++; $display("FAIL full_rsp1 got=%b/%h/%b want=%b/%h/1", b1.req_recv, b1.req_rdata, b1.tgt_ack, 4'(1 << r.ch), r.rd); end
        total++; if (b1.tgt_req !== 1'b0 || b1.req_gnt !== 4'b0) begin
            bad++; $display("FAIL full_nobypass got=%b/%b want=0/0000", b1.tgt_req, b1.req_gnt); end
        r = rsp_q.pop_front();
        @(posedge g_clk); #1;
        b1.req_req = '0; b1.tgt_rdata = r.rd;
        #4;
        total++; if (b1.req_recv !== 4'(1 << r.ch) || b1.req_rdata !== r.rd || out1 !== 2'd1) begin
            bad++; $display("FAIL full_rsp2 got=%b/%h/%0d want=%b/%h/1", b1.req_recv, b1.req_rdata, out1, 4'(1 << r.ch), r.rd); end
        @(posedge g_clk); #1;
        b1.tgt_recv = 1'b0;
        #4;
        total++; if (out1 !== 2'd0) begin bad++; $display("FAIL full_empty got=%0d want=0", out1); end
    endtask

    task automatic test_backpressure;
        rsp_t r;
        rsp_q.delete();
        @(posedge g_clk); #1;
        b1.req_req = 4'b0100; b1.tgt_gnt = 1'b1;
        #4;
        total++; if (b1.req_gnt !== 4'b0100) begin bad++; $display("FAIL bp_gnt got=%b want=0100", b1.req_gnt); end
        rsp_q.push_back('{ch: 2, rd: 64'h77});
        r = rsp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            @(posedge g_clk); #1;
            b1.req_req = '0; b1.tgt_gnt = 1'b0; b1.tgt_recv = 1'b1; b1.tgt_rdata = r.rd;
            b1.req_ack = (k < 3) ? 4'b1011 : 4'b1111;
            #4;
            total++; if (b1.tgt_ack !== (k == 3) || b1.req_recv !== 4'(1 << r.ch) || out1 !== 2'd1) begin
                bad++; $display("FAIL bp_cyc%0d got=%b/%b/%0d want=%b/%b/1", k, b1.tgt_ack, b1.req_recv, out1, (k == 3), 4'(1 << r.ch)); end
        end
        @(posedge g_clk); #1;
        b1.tgt_recv = 1'b0;
        #4;
        total++; if (out1 !== 2'd0) begin bad++; $display("FAIL bp_popped got=%0d want=0", out1); end
    endtask

    task automatic test_reset_mid;
        @(posedge g_clk); #1;
        b1.req_req = 4'b0011; b1.tgt_gnt = 1'b1;
        #4;
        total++; if (b1.req_gnt !== 4'b0001) begin bad++; $display("FAIL rm_gnt0 got=%b want=0001", b1.req_gnt); end
        @(posedge g_clk); #1;
        b1.req_req = 4'b0010;
        #4;
        total++; if (b1.req_gnt !== 4'b0010) begin bad++; $display("FAIL rm_gnt1 got=%b want=0010", b1.req_gnt); end
        @(posedge g_clk); #1;
        b1.tgt_gnt = 1'b0;
        #4;
        total++; if (out1 !== 2'd2) begin bad++; $display("FAIL rm_outstanding got=%0d want=2", out1); end
        #2;
        g_reset = 1'b1;
        #1;
        total++; if (out1 !== 2'd0 || b1.tgt_req !== 1'b0 || b1.req_gnt !== 4'b0 || b1.req_recv !== 4'b0 || b1.tgt_ack !== 1'b0 || stray1 !== 1'b0) begin
            bad++; $display("FAIL rm_async got=%0d/%b/%b/%b/%b/%b want=0/0/0000/0000/0/0",
                            out1, b1.tgt_req, b1.req_gnt, b1.req_recv, b1.tgt_ack, stray1); end
        b1.req_req = '0;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        b1.tgt_recv = 1'b1; b1.tgt_rdata = 64'hBAD;
        #4;
        total++; if (b1.tgt_ack !== 1'b1 || b1.req_recv !== 4'b0) begin
            bad++; $display("FAIL rm_stray_drain got=%b/%b want=1/0000", b1.tgt_ack, b1.req_recv); end
        @(posedge g_clk); #1;
        b1.tgt_recv = 1'b0;
        #4;
        total++; if (stray1 !== 1'b1) begin bad++; $display("FAIL rm_stray_flag got=%b want=1", stray1); end
        @(posedge g_clk); #5;
        total++; if (stray1 !== 1'b1 || out1 !== 2'd0) begin bad++; $display("FAIL rm_stray_sticky got=%b/%0d want=1/0", stray1, out1); end
    endtask

    initial begin
        init_buses();
        test_reset();
        test_fixed_priority();
        test_lock();
        test_round_robin();
        test_full_and_responses();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
